// File: rtl/key_uart_tx_top.sv
// Push-button UART demo: debounced active-low key sends one UART frame carrying a press counter.
// Define KEY_UART_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
`timescale 1ns/1ps

module key_uart_tx_top #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD            = 115200,
    parameter int CLKS_PER_BIT    = CLK_FREQ / BAUD,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic tx
);

    // state  | meaning
    // IDLE   | line idle high, waiting for a press event
    // START  | start bit (low)
    // DATA   | 8 data bits, LSB first
    // PARITY | even parity over the data byte (KEY_UART_PARITY_EN only)
    // STOP   | stop bit (high), then back to IDLE
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef KEY_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic          key_meta;
    logic          key_sync;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          press_pulse;

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    press_cnt;
`ifdef KEY_UART_PARITY_EN
    logic          par_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level    <= 1'b1;
            db_cnt      <= '0;
            press_pulse <= 1'b0;
        end else if (key_sync == db_level) begin
            db_cnt      <= '0;
            press_pulse <= 1'b0;
        end else if (db_cnt == DB_LAST) begin
            db_level    <= key_sync;
            db_cnt      <= '0;
            press_pulse <= ~key_sync;
        end else begin
            db_cnt      <= db_cnt + 1'b1;
            press_pulse <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            press_cnt <= '0;
`ifdef KEY_UART_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (press_pulse) begin
                        shreg     <= press_cnt;
`ifdef KEY_UART_PARITY_EN
                        par_bit   <= ^press_cnt;
`endif
                        press_cnt <= press_cnt + 1'b1;
                        tx        <= 1'b0;
                        baud_cnt  <= BAUD_LOAD;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        tx       <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef KEY_UART_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef KEY_UART_PARITY_EN
                PARITY: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_uart_tx_top.sv
// Directed bench for key_uart_tx_top: debounce, framing, drop-while-busy and async abort.
// Parity checks are active when KEY_UART_PARITY_EN is defined for the build.
`timescale 1ns/1ps

module tb_key_uart_tx_top;

    localparam int CPB = 16;
    localparam int DEB = 50;
`ifdef KEY_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk;
    logic rst_n;
    logic key;
    logic tx;

    int tests = 0;
    int fails = 0;

    key_uart_tx_top #(
        .CLKS_PER_BIT   (CPB),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input int n, input string tag);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    task automatic wait_start(input int bound, output logic got, output int lat);
        int i = 0;
        got = 1'b0;
        lat = 0;
        while (!got && i < bound) begin
            @(negedge clk);
            i++;
            if (tx === 1'b0) begin
                got = 1'b1;
                lat = i;
            end
        end
    endtask

    // Called on the first negedge where tx is low; walks the whole frame.
    task automatic read_frame(output logic [7:0] data, output logic start_ok,
                              output logic par, output logic stop_ok);
        int b;
        int ph;
        data = '0; start_ok = 1'b1; par = 1'b0; stop_ok = 1'b1;
        for (int c = 0; c < FRAME_BITS * CPB; c++) begin
            if (c > 0) @(negedge clk);
            b  = c / CPB;
            ph = c % CPB;
            if (b == 0) begin
                if (tx !== 1'b0) start_ok = 1'b0;
            end else if (b <= 8) begin
                if (ph == CPB / 2) data[b-1] = tx;
            end else if (b == FRAME_BITS - 1) begin
                if (tx !== 1'b1) stop_ok = 1'b0;
            end else begin
                if (ph == CPB / 2) par = tx;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_byte, input logic [7:0] data,
                               input logic start_ok, input logic par, input logic stop_ok);
        check({tag, "_byte"}, 32'(data), 32'(exp_byte));
        check({tag, "_start"}, 32'(start_ok), 32'd1);
        check({tag, "_stop"}, 32'(stop_ok), 32'd1);
`ifdef KEY_UART_PARITY_EN
        check({tag, "_parity"}, 32'(par), 32'(^exp_byte));
`endif
    endtask

    initial begin
        logic       got;
        int         lat;
        logic [7:0] d;
        logic       s_ok;
        logic       p;
        logic       st_ok;

        // reset with key released
        rst_n = 1'b0;
        key   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_tx_early", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        check("reset_tx_late", 32'(tx), 32'd1);
        rst_n = 1'b1;
        expect_idle(60, "idle_after_reset");

        // first press -> 0x00
        key = 1'b0;
        wait_start(200, got, lat);
        check("p1_seen", 32'(got), 32'd1);
        check("p1_latency_in_51_55", 32'(lat >= 51 && lat <= 55), 32'd1);
        read_frame(d, s_ok, p, st_ok);
        check_frame("p1", 8'h00, d, s_ok, p, st_ok);
        expect_idle(40, "p1_hold_no_repeat");
        key = 1'b1;
        expect_idle(100, "p1_release_no_frame");

        // second press -> 0x01
        key = 1'b0;
        wait_start(200, got, lat);
        check("p2_seen", 32'(got), 32'd1);
        read_frame(d, s_ok, p, st_ok);
        check_frame("p2", 8'h01, d, s_ok, p, st_ok);
        key = 1'b1;
        expect_idle(100, "p2_release_no_frame");

        // short glitch must be ignored
        key = 1'b0;
        expect_idle(40, "glitch_low_no_frame");
        key = 1'b1;
        expect_idle(100, "glitch_after_no_frame");

        // press -> 0x02; a second press completing during the frame is dropped
        key = 1'b0;
        wait_start(200, got, lat);
        check("p3_seen", 32'(got), 32'd1);
        fork
            begin
                repeat (40) @(negedge clk);
                key = 1'b1;
                repeat (60) @(negedge clk);
                key = 1'b0;
            end
        join_none
        read_frame(d, s_ok, p, st_ok);
        check_frame("p3", 8'h02, d, s_ok, p, st_ok);
        expect_idle(100, "busy_press_dropped");
        key = 1'b1;
        expect_idle(80, "p3_release_no_frame");

        // next press carries 0x03: no skipped value
        key = 1'b0;
        wait_start(200, got, lat);
        check("p4_seen", 32'(got), 32'd1);
        read_frame(d, s_ok, p, st_ok);
        check_frame("p4", 8'h03, d, s_ok, p, st_ok);
        key = 1'b1;
        expect_idle(80, "p4_release_no_frame");

        // press -> 0x04, abort during data bit 0 (low)
        key = 1'b0;
        wait_start(200, got, lat);
        check("p5_seen", 32'(got), 32'd1);
        repeat (19) @(negedge clk);
        check("abort_pre_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx_async_high", 32'(tx), 32'd1);
        key = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_tx_held_high", 32'(tx), 32'd1);
        rst_n = 1'b1;
        expect_idle(80, "after_abort_idle");

        // counter cleared by reset -> 0x00, then 0x01 (parity 1 when enabled)
        key = 1'b0;
        wait_start(200, got, lat);
        check("p6_seen", 32'(got), 32'd1);
        read_frame(d, s_ok, p, st_ok);
        check_frame("p6", 8'h00, d, s_ok, p, st_ok);
        key = 1'b1;
        expect_idle(80, "p6_release_no_frame");

        key = 1'b0;
        wait_start(200, got, lat);
        check("p7_seen", 32'(got), 32'd1);
        read_frame(d, s_ok, p, st_ok);
        check_frame("p7", 8'h01, d, s_ok, p, st_ok);
        key = 1'b1;
        expect_idle(80, "p7_release_no_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
